// File: rtl/n8_pkg.sv
// Shared definitions for the N8 serial gamepad reader: bit positions and FSM states.
package n8_pkg;

    localparam int N8_BITS = 8;

    // Shift order from the pad, index 0 arrives first
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [2:0] {
        ST_LATCH,
        ST_LOW,
        ST_HIGH,
        ST_DONE,
        ST_IDLE
    } n8_state_t;

endpackage

// File: rtl/n8_sync.sv
// Two-flop synchronizer for the pad data line; resets to 1 (line idle, nothing pressed).
module n8_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/n8_reader.sv
// N8 pad reader: drives latch/pulse, shifts in 8 active-low bits, publishes a whole frame at once.
// Optional N8_FRAME_FILTER_EN: per-button two-frame agreement, all-pressed frame reads as disconnect.
module n8_reader
    import n8_pkg::*;
#(
    parameter int LATCH_CYCLES = 600,
    parameter int HALF_CYCLES  = 150,
    parameter int POLL_CYCLES  = 833333
) (
    input  logic clk,
    input  logic reset,
    input  logic n8_data,
    output logic n8_latch,
    output logic n8_pulse,
    output logic n8_a,
    output logic n8_b,
    output logic n8_select,
    output logic n8_start,
    output logic n8_up,
    output logic n8_down,
    output logic n8_left,
    output logic n8_right,
    output logic frame_valid
);

    localparam int CMAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int PW   = $clog2(POLL_CYCLES + 1);

    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES);
    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYCLES - 1);
    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES);

    n8_state_t          st;
    logic [CW-1:0]      cnt;
    logic [PW-1:0]      pcnt;
    logic [2:0]         bit_idx;
    logic [N8_BITS-1:0] sr;
    logic [N8_BITS-1:0] sr_smp;
    logic [N8_BITS-1:0] raw;
    logic [N8_BITS-1:0] btn;
    logic [N8_BITS-1:0] btn_next;
    logic               data_s;

    n8_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (n8_data),
        .q     (data_s)
    );

`ifdef N8_FRAME_FILTER_EN
    logic [N8_BITS-1:0] prev;
    logic [N8_BITS-1:0] agree;
`endif

    // Shift register with the bit being sampled this cycle already folded in, so the
    // last bit of a frame reaches the outputs on the same edge that enters DONE.
    always_comb begin
        sr_smp          = sr;
        sr_smp[bit_idx] = data_s;
        raw             = ~sr_smp;
`ifdef N8_FRAME_FILTER_EN
        agree    = ~(raw ^ prev);
        btn_next = (&raw) ? '0 : ((agree & raw) | (~agree & btn));
`else
        btn_next = raw;
`endif
    end

    // In LATCH, cnt counts the high cycles 1..LATCH_CYCLES; the reset cycle is cnt=0 with
    // latch still low, so the first high cycle is the first one after reset releases.
    // pcnt is 1 in the first latch cycle, so the next latch lands exactly POLL_CYCLES later.
    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= ST_LATCH;
            cnt         <= '0;
            pcnt        <= '0;
            bit_idx     <= '0;
            sr          <= '0;
            btn         <= '0;
            n8_latch    <= 1'b0;
            n8_pulse    <= 1'b0;
            frame_valid <= 1'b0;
`ifdef N8_FRAME_FILTER_EN
            prev        <= '0;
`endif
        end else begin
            frame_valid <= 1'b0;
            pcnt        <= pcnt + 1'b1;
            case (st)
                ST_LATCH: begin
                    if (cnt == LATCH_LAST) begin
                        st       <= ST_LOW;
                        cnt      <= '0;
                        bit_idx  <= '0;
                        n8_latch <= 1'b0;
                    end else begin
                        cnt      <= cnt + 1'b1;
                        n8_latch <= 1'b1;
                    end
                end
                ST_LOW: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        sr  <= sr_smp;
                        if (bit_idx == 3'd7) begin
                            st          <= ST_DONE;
                            btn         <= btn_next;
                            frame_valid <= 1'b1;
`ifdef N8_FRAME_FILTER_EN
                            prev        <= (&raw) ? '0 : raw;
`endif
                        end else begin
                            st       <= ST_HIGH;
                            n8_pulse <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (cnt == HALF_LAST) begin
                        st       <= ST_LOW;
                        cnt      <= '0;
                        bit_idx  <= bit_idx + 1'b1;
                        n8_pulse <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    st <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (pcnt >= POLL_LAST) begin
                        st       <= ST_LATCH;
                        cnt      <= CW'(1);
                        pcnt     <= PW'(1);
                        n8_latch <= 1'b1;
                    end
                end
                default: begin
                    st <= ST_IDLE;
                end
            endcase
        end
    end

    assign n8_a      = btn[BTN_A];
    assign n8_b      = btn[BTN_B];
    assign n8_select = btn[BTN_SELECT];
    assign n8_start  = btn[BTN_START];
    assign n8_up     = btn[BTN_UP];
    assign n8_down   = btn[BTN_DOWN];
    assign n8_left   = btn[BTN_LEFT];
    assign n8_right  = btn[BTN_RIGHT];

endmodule

// File: tb/tb_n8_reader.sv
// Bench for n8_reader: live pad model on latch/pulse, frame-level reference model of the button outputs.
module tb_n8_reader;

    localparam int LC    = 4;
    localparam int HC    = 3;
    localparam int PC    = 64;
    localparam int FRAME = LC + 15 * HC + 1;
    localparam int BOUND = 200;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic n8_data;
    logic n8_latch, n8_pulse, frame_valid;
    logic n8_a, n8_b, n8_select, n8_start, n8_up, n8_down, n8_left, n8_right;

    n8_reader #(
        .LATCH_CYCLES (LC),
        .HALF_CYCLES  (HC),
        .POLL_CYCLES  (PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .n8_data     (n8_data),
        .n8_latch    (n8_latch),
        .n8_pulse    (n8_pulse),
        .n8_a        (n8_a),
        .n8_b        (n8_b),
        .n8_select   (n8_select),
        .n8_start    (n8_start),
        .n8_up       (n8_up),
        .n8_down     (n8_down),
        .n8_left     (n8_left),
        .n8_right    (n8_right),
        .frame_valid (frame_valid)
    );

    always #5 clk = ~clk;

    // Pad: latch rewinds to bit 0, each pulse rise advances; line level is live (0 = pressed)
    logic [7:0] pad_lvl = 8'hFF;
    int         pad_idx = 0;

    always @(posedge n8_latch or posedge n8_pulse) begin
        if (n8_latch) pad_idx <= 0;
        else          pad_idx <= pad_idx + 1;
    end

    assign n8_data = (pad_idx < 8) ? pad_lvl[pad_idx[2:0]] : 1'b1;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_out;
    logic [7:0] m_prev;

    function automatic logic [7:0] btns();
        return {n8_right, n8_left, n8_down, n8_up, n8_start, n8_select, n8_b, n8_a};
    endfunction

    task automatic model_reset();
        m_out  = 8'h00;
        m_prev = 8'h00;
    endtask

    // Expected outputs after a frame whose sampled bits (1 = pressed) are 'pressed'
    task automatic model_apply(input logic [7:0] pressed);
`ifdef N8_FRAME_FILTER_EN
        if (pressed == 8'hFF) begin
            m_out  = 8'h00;
            m_prev = 8'h00;
        end else begin
            for (int i = 0; i < 8; i++)
                if (pressed[i] == m_prev[i]) m_out[i] = pressed[i];
            m_prev = pressed;
        end
`else
        m_out = pressed;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
    endtask

    // Runs until frame_valid; 'stable' drops if outputs leave the previous model value early
    task automatic run_to_fv(output int cyc, output bit got, output bit stable);
        cyc = 0; got = 1'b0; stable = 1'b1;
        while (cyc < BOUND && !got) begin
            @(negedge clk);
            cyc++;
            if (frame_valid) got = 1'b1;
            else if (btns() !== m_out) stable = 1'b0;
        end
    endtask

    // Waits for a latch, then for the pulse that moves the pad to bit 'idx'
    task automatic wait_pulse(input int idx, output bit ok);
        bit seen = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < BOUND && !ok; c++) begin
            @(negedge clk);
            if (n8_latch) seen = 1'b1;
            if (seen && n8_pulse && pad_idx == idx) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        int  rises = 0;
        bit  pp = 1'b0;
        pad_lvl = 8'hFF;
        do_reset();
        checks++;
        if ({n8_latch, n8_pulse, frame_valid} !== 3'b000 || btns() !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: latch/pulse/fv=%b btns=%h, expected 000 and 00",
                     {n8_latch, n8_pulse, frame_valid}, btns());
        end
        reset = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            int p, off;
            bit el, ep, ef;
            @(negedge clk);
            p   = ((c - 1) % PC) + 1;
            off = p - LC - 1;
            el  = (p <= LC);
            ep  = (off >= 0) && (off < 15 * HC) && (((off / HC) % 2) == 1);
            ef  = (p == FRAME);
            checks++;
            if ({n8_latch, n8_pulse, frame_valid} !== {el, ep, ef}) begin
                errors++;
                $display("FAIL timing cycle %0d: latch/pulse/fv=%b expected %b",
                         c, {n8_latch, n8_pulse, frame_valid}, {el, ep, ef});
            end
            if (n8_pulse && !pp && c <= FRAME) rises++;
            pp = n8_pulse;
            if (c == FRAME) begin
                checks++;
                if (btns() !== 8'h00) begin
                    errors++;
                    $display("FAIL idle_pad_buttons: got %h expected 00", btns());
                end
            end
        end
        checks++;
        if (rises != 7) begin
            errors++;
            $display("FAIL pulse_count: got %0d expected 7", rises);
        end
    endtask

    task automatic test_pattern(input string name, input logic [7:0] pressed);
        int cyc; bit got, stable, held;
        pad_lvl = ~pressed;
        do_reset();
        reset = 1'b0;
        run_to_fv(cyc, got, stable);
        checks++;
        if (!got || cyc != FRAME || !stable) begin
            errors++;
            $display("FAIL %s_frame: fv_cycle=%0d got=%0d stable=%0d expected cycle %0d",
                     name, cyc, got, stable, FRAME);
        end
        model_apply(pressed);
        checks++;
        if (btns() !== m_out) begin
            errors++;
            $display("FAIL %s_buttons: got %h expected %h", name, btns(), m_out);
        end
        held = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (btns() !== m_out || frame_valid) held = 1'b0;
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL %s_hold: got %h expected %h held through idle", name, btns(), m_out);
        end
    endtask

    task automatic test_midframe();
        int cyc; bit got, stable, ok;
        logic [7:0] up_p   = 8'h10;
        logic [7:0] down_p = 8'h20;
        pad_lvl = ~up_p;
        do_reset();
        reset = 1'b0;
        wait_pulse(5, ok);
        pad_lvl = ~down_p;
        run_to_fv(cyc, got, stable);
        checks++;
        if (!ok || !got || !stable) begin
            errors++;
            $display("FAIL midframe_seq: pulse_ok=%0d got=%0d stable=%0d expected 1 1 1", ok, got, stable);
        end
        // Bits 0..4 were sampled before the switch, 5..7 after
        model_apply((up_p & 8'h1F) | (down_p & 8'hE0));
        checks++;
        if (btns() !== m_out) begin
            errors++;
            $display("FAIL midframe_buttons: got %h expected %h", btns(), m_out);
        end
    endtask

    task automatic test_reset_midframe();
        int cyc; bit got, stable, ok;
        logic [7:0] pressed = 8'($urandom) | 8'h01;
        if (pressed == 8'hFF) pressed = 8'h7F;
        pad_lvl = ~pressed;
        do_reset();
        reset = 1'b0;
        for (int f = 0; f < 2; f++) begin
            run_to_fv(cyc, got, stable);
            model_apply(pressed);
        end
        checks++;
        if (btns() !== m_out) begin
            errors++;
            $display("FAIL pre_reset_buttons: got %h expected %h", btns(), m_out);
        end
        wait_pulse(4, ok);
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        checks++;
        if (!ok || {n8_latch, n8_pulse, frame_valid} !== 3'b000 || btns() !== 8'h00) begin
            errors++;
            $display("FAIL midframe_reset: ok=%0d latch/pulse/fv=%b btns=%h expected 1 000 00",
                     ok, {n8_latch, n8_pulse, frame_valid}, btns());
        end
        @(negedge clk);
        reset = 1'b0;
        run_to_fv(cyc, got, stable);
        checks++;
        if (!got || cyc != FRAME || !stable) begin
            errors++;
            $display("FAIL post_reset_frame: fv_cycle=%0d got=%0d stable=%0d expected %0d",
                     cyc, got, stable, FRAME);
        end
        model_apply(pressed);
        checks++;
        if (btns() !== m_out) begin
            errors++;
            $display("FAIL post_reset_buttons: got %h expected %h", btns(), m_out);
        end
    endtask

    task automatic test_back_to_back();
        int cyc; bit got, stable;
        logic [7:0] pressed = 8'h00;
        do_reset();
        for (int f = 0; f < 8; f++) begin
            if (f % 2 == 0) pressed = 8'($urandom);
            pad_lvl = ~pressed;
            if (f == 0) reset = 1'b0;
            run_to_fv(cyc, got, stable);
            checks++;
            if (!got || !stable || cyc != ((f == 0) ? FRAME : PC)) begin
                errors++;
                $display("FAIL b2b_frame%0d: interval=%0d got=%0d stable=%0d expected %0d",
                         f, cyc, got, stable, (f == 0) ? FRAME : PC);
            end
            model_apply(pressed);
            checks++;
            if (btns() !== m_out) begin
                errors++;
                $display("FAIL b2b_buttons%0d: got %h expected %h", f, btns(), m_out);
            end
        end
    endtask

`ifdef N8_FRAME_FILTER_EN
    task automatic test_filter();
        int cyc; bit got, stable;
        logic [7:0] seq [4] = '{8'h01, 8'h00, 8'h01, 8'h01};
        bit         exp_a [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int f = 0; f < 4; f++) begin
            pad_lvl = ~seq[f];
            if (f == 0) reset = 1'b0;
            run_to_fv(cyc, got, stable);
            checks++;
            if (!got || n8_a !== exp_a[f]) begin
                errors++;
                $display("FAIL filter_a%0d: got=%0d n8_a=%b expected 1 %b", f, got, n8_a, exp_a[f]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_pattern("none", 8'h00);
        test_pattern("start_left", 8'h48);
        test_pattern("all", 8'hFF);
        test_pattern("rand", 8'($urandom));
        test_midframe();
        test_reset_midframe();
        test_back_to_back();
`ifdef N8_FRAME_FILTER_EN
        test_filter();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
